// File: rtl/capture32.sv
// capture32: 32-bit input-capture unit timing edge-to-edge intervals in prescaled ticks.
// Define CAPTURE32_SYNC_EN to pass CAPIN through a 2-flop synchronizer first.
module capture32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CAPIN,
    input  logic [31:0] PRE,
    input  logic [1:0]  MODE,
    input  logic        CAPEN,
    input  logic        CAPDONECLR,
    input  logic        CAPOVCLR,
    output logic [31:0] CAP,
    output logic        CAPDONE,
    output logic        CAPOVR,
    output logic        CAPOV
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
    state_t      r_state, w_state_nxt;
    logic        r_prev, r_done, r_ovr, r_ov;
    logic        w_s, w_rise, w_fall, w_start, w_end, w_tick, w_max, w_cap, w_ov;
    logic [31:0] r_cnt, r_clkdiv, r_cap, w_cnt_nxt, w_clkdiv_nxt, w_cnt_inc;
`ifdef CAPTURE32_SYNC_EN
    logic [1:0]  r_sync;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_sync <= '0;
        else r_sync <= {r_sync[0], CAPIN};
    assign w_s = r_sync[1];
`else
    assign w_s = CAPIN;
`endif
    assign w_rise    = w_s & ~r_prev;
    assign w_fall    = ~w_s & r_prev;
    // period modes share one edge; width modes end on the opposite edge
    assign w_start   = MODE[0] ? w_fall : w_rise;
    assign w_end     = (MODE[1] ^ MODE[0]) ? w_fall : w_rise;
    assign w_tick    = (r_clkdiv == PRE);
    assign w_max     = &r_cnt;
    assign w_cnt_inc = w_max ? r_cnt : r_cnt + 32'd1;
    assign w_cap     = CAPEN && (r_state == MEAS) && w_end;
    assign w_ov      = CAPEN && (r_state == MEAS) && w_tick && w_max;
    always_comb begin
        w_state_nxt  = IDLE;
        w_cnt_nxt    = '0;
        w_clkdiv_nxt = '0;
        if (CAPEN) begin
            case (r_state)
                IDLE:    w_state_nxt = ARM;
                ARM:     w_state_nxt = w_start ? MEAS : ARM;
                MEAS: begin
                    w_state_nxt = (w_end && MODE[1]) ? ARM : MEAS;
                    if (!w_end) begin
                        w_cnt_nxt    = w_tick ? w_cnt_inc : r_cnt;
                        w_clkdiv_nxt = w_tick ? 32'd0 : r_clkdiv + 32'd1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_clkdiv <= '0;
            r_prev   <= 1'b0;
            r_cap    <= '0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
            r_ov     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_clkdiv <= w_clkdiv_nxt;
            r_prev   <= w_s;
            if (w_cap) r_cap <= w_tick ? w_cnt_inc : r_cnt;
            r_done   <= !CAPDONECLR && (r_done || w_cap);
            r_ovr    <= !CAPDONECLR && (r_ovr || (w_cap && r_done));
            r_ov     <= !CAPOVCLR && (r_ov || w_ov);
        end
    assign CAP     = r_cap;
    assign CAPDONE = r_done;
    assign CAPOVR  = r_ovr;
    assign CAPOV   = r_ov;
endmodule
